// File: rtl/pc_unit.sv
// Program-counter stage: sequential fetch address with stall, halt/resume,
// redirect, and a circular return-address stack for call/ret.
//
// state   | meaning
// RUN     | PC advances, redirects and RAS operations honoured
// HALTED  | PC and RAS frozen until resume (without halt)
module pc_unit #(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned STEP         = 2,
  parameter int unsigned RESET_VECTOR = 0,
  parameter int unsigned RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             halt,
  input  logic             resume,
  input  logic             redirect,
  input  logic             call,
  input  logic             ret,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic [WIDTH-1:0] pc,
  output logic             halted,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_err
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
  localparam logic [PW-1:0] PTR_MAX = PW'(RAS_DEPTH - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(RAS_DEPTH);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [WIDTH-1:0] ras_d [RAS_DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             err_q, err_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;

  logic [WIDTH-1:0] pc_next_seq;
  logic [PW-1:0]    ptr_inc, ptr_dec;
  logic             active;

  assign pc_next_seq = pc_q + WIDTH'(STEP);
  // Explicit wrap so non-power-of-two depths still behave as a ring.
  assign ptr_inc     = (wptr_q == PTR_MAX) ? '0 : wptr_q + PW'(1);
  assign ptr_dec     = (wptr_q == '0) ? PTR_MAX : wptr_q - PW'(1);
  assign active      = (state_q == RUN) && !halt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= WIDTH'(RESET_VECTOR);
      wptr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) ras_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      err_q   <= err_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      ras_q   <= ras_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (halt) state_d = HALTED;
      HALTED:  if (resume && !halt) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    ras_d   = ras_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    err_d   = 1'b0;
    if (active) begin
      if (ret) begin
        if (count_q == '0) begin
          pc_d  = redirect_pc;
          err_d = 1'b1;
        end else begin
          pc_d    = ras_q[ptr_dec];
          wptr_d  = ptr_dec;
          count_d = count_q - CW'(1);
        end
      end else if (call) begin
        // When full, wptr already points at the oldest entry, so the push
        // overwrites it and the count saturates.
        ras_d[wptr_q] = pc_next_seq;
        wptr_d        = ptr_inc;
        pc_d          = redirect_pc;
        if (count_q == CNT_MAX) err_d = 1'b1;
        else count_d = count_q + CW'(1);
      end else if (redirect) begin
        pc_d = redirect_pc;
      end else if (!stall) begin
        pc_d = pc_next_seq;
      end
    end
    empty_d = (count_d == '0);
    full_d  = (count_d == CNT_MAX);
  end

  always_comb begin
    pc        = pc_q;
    halted    = (state_q == HALTED);
    ras_empty = empty_q;
    ras_full  = full_q;
    ras_err   = err_q;
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed vector bench for pc_unit: default 16-bit instance and an 8-bit,
// step-4, depth-3 instance for wrap and ring-pointer corner cases.
module tb_pc_unit;

  localparam logic [6:0] NO = 7'b0000000;
  localparam logic [6:0] R  = 7'b1000000;
  localparam logic [6:0] ST = 7'b0100000;
  localparam logic [6:0] HA = 7'b0010000;
  localparam logic [6:0] RS = 7'b0001000;
  localparam logic [6:0] RD = 7'b0000100;
  localparam logic [6:0] CA = 7'b0000010;
  localparam logic [6:0] RT = 7'b0000001;
  // flags: {halted, ras_empty, ras_full, ras_err}

  typedef struct {
    logic [6:0]  ctl;
    logic [15:0] rp;
    logic [15:0] exp_pc;
    logic [3:0]  exp_flags;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, stall, halt, resume, redirect, call, ret;
  logic [15:0] redirect_pc;
  logic [15:0] pc_a;
  logic [7:0]  pc_b;
  logic        halted_a, empty_a, full_a, err_a;
  logic        halted_b, empty_b, full_b, err_b;

  int n_vec = 0;
  int n_err = 0;

  vec_t va[$];
  vec_t vb[$];

  always #5 clk = ~clk;

  pc_unit dut_a (
    .clk(clk), .rst(rst), .stall(stall), .halt(halt), .resume(resume),
    .redirect(redirect), .call(call), .ret(ret), .redirect_pc(redirect_pc),
    .pc(pc_a), .halted(halted_a), .ras_empty(empty_a), .ras_full(full_a),
    .ras_err(err_a)
  );

  pc_unit #(.WIDTH(8), .STEP(4), .RESET_VECTOR(8'hF0), .RAS_DEPTH(3)) dut_b (
    .clk(clk), .rst(rst), .stall(stall), .halt(halt), .resume(resume),
    .redirect(redirect), .call(call), .ret(ret), .redirect_pc(redirect_pc[7:0]),
    .pc(pc_b), .halted(halted_b), .ras_empty(empty_b), .ras_full(full_b),
    .ras_err(err_b)
  );

  function automatic vec_t mk(logic [6:0] ctl, logic [15:0] rp, logic [15:0] p,
                              logic [3:0] f);
    vec_t v;
    v.ctl = ctl; v.rp = rp; v.exp_pc = p; v.exp_flags = f;
    return v;
  endfunction

  task automatic apply(input vec_t v, input bit use_b, input string name, input int idx);
    logic [15:0] act_pc;
    logic [3:0]  act_f;
    @(negedge clk);
    {rst, stall, halt, resume, redirect, call, ret} = v.ctl;
    redirect_pc = v.rp;
    @(posedge clk);
    #1;
    if (use_b) begin
      act_pc = {8'h00, pc_b};
      act_f  = {halted_b, empty_b, full_b, err_b};
    end else begin
      act_pc = pc_a;
      act_f  = {halted_a, empty_a, full_a, err_a};
    end
    n_vec++;
    if (act_pc !== v.exp_pc || act_f !== v.exp_flags) begin
      n_err++;
      $display("FAIL %s[%0d]: got pc=%h flags(h,e,f,err)=%b, want pc=%h flags=%b",
               name, idx, act_pc, act_f, v.exp_pc, v.exp_flags);
    end
  endtask

  initial begin
    {rst, stall, halt, resume, redirect, call, ret} = R;
    redirect_pc = '0;

    // Default instance: WIDTH=16, STEP=2, RESET_VECTOR=0, RAS_DEPTH=4.
    va.push_back(mk(R,       16'h0000, 16'h0000, 4'b0100));
    va.push_back(mk(NO,      16'h0000, 16'h0002, 4'b0100));
    va.push_back(mk(NO,      16'h0000, 16'h0004, 4'b0100));
    va.push_back(mk(NO,      16'h0000, 16'h0006, 4'b0100));
    va.push_back(mk(NO,      16'h0000, 16'h0008, 4'b0100));
    va.push_back(mk(ST|RD,   16'h0100, 16'h0100, 4'b0100));
    va.push_back(mk(ST,      16'h0000, 16'h0100, 4'b0100));
    va.push_back(mk(ST,      16'h0000, 16'h0100, 4'b0100));
    va.push_back(mk(RD,      16'h0010, 16'h0010, 4'b0100));
    va.push_back(mk(CA,      16'h0200, 16'h0200, 4'b0000));
    va.push_back(mk(NO,      16'h0000, 16'h0202, 4'b0000));
    va.push_back(mk(NO,      16'h0000, 16'h0204, 4'b0000));
    va.push_back(mk(RT,      16'h0000, 16'h0012, 4'b0100));
    va.push_back(mk(RD,      16'h0010, 16'h0010, 4'b0100));
    va.push_back(mk(CA,      16'h0020, 16'h0020, 4'b0000));
    va.push_back(mk(CA,      16'h0030, 16'h0030, 4'b0000));
    va.push_back(mk(CA,      16'h0040, 16'h0040, 4'b0000));
    va.push_back(mk(CA,      16'h0050, 16'h0050, 4'b0010));
    va.push_back(mk(CA,      16'h0060, 16'h0060, 4'b0011));
    va.push_back(mk(NO,      16'h0000, 16'h0062, 4'b0010));
    va.push_back(mk(RT,      16'h0000, 16'h0052, 4'b0000));
    va.push_back(mk(RT,      16'h0000, 16'h0042, 4'b0000));
    va.push_back(mk(RT,      16'h0000, 16'h0032, 4'b0000));
    va.push_back(mk(RT,      16'h0000, 16'h0022, 4'b0100));
    va.push_back(mk(RT,      16'h0900, 16'h0900, 4'b0101));
    va.push_back(mk(NO,      16'h0000, 16'h0902, 4'b0100));
    va.push_back(mk(CA,      16'h0030, 16'h0030, 4'b0000));
    va.push_back(mk(HA|RT,   16'h0000, 16'h0030, 4'b1000));
    va.push_back(mk(RD|ST|CA,16'h0500, 16'h0030, 4'b1000));
    va.push_back(mk(RT,      16'h0700, 16'h0030, 4'b1000));
    va.push_back(mk(HA|RS,   16'h0000, 16'h0030, 4'b1000));
    va.push_back(mk(RS,      16'h0000, 16'h0030, 4'b0000));
    va.push_back(mk(NO,      16'h0000, 16'h0032, 4'b0000));
    va.push_back(mk(RT,      16'h0000, 16'h0904, 4'b0100));
    va.push_back(mk(CA,      16'h0100, 16'h0100, 4'b0000));
    va.push_back(mk(CA,      16'h0100, 16'h0100, 4'b0000));
    va.push_back(mk(CA,      16'h0100, 16'h0100, 4'b0000));
    va.push_back(mk(CA,      16'h0100, 16'h0100, 4'b0010));
    va.push_back(mk(HA,      16'h0000, 16'h0100, 4'b1010));
    va.push_back(mk(R|CA|RS, 16'h0300, 16'h0000, 4'b0100));
    va.push_back(mk(NO,      16'h0000, 16'h0002, 4'b0100));
    va.push_back(mk(CA|RD,   16'h0080, 16'h0080, 4'b0000));
    va.push_back(mk(RT|CA,   16'h0700, 16'h0004, 4'b0100));
    va.push_back(mk(RT|CA,   16'h0033, 16'h0033, 4'b0101));

    // Narrow instance: WIDTH=8, STEP=4, RESET_VECTOR=0xF0, RAS_DEPTH=3.
    vb.push_back(mk(R,       16'h0000, 16'h00F0, 4'b0100));
    vb.push_back(mk(NO,      16'h0000, 16'h00F4, 4'b0100));
    vb.push_back(mk(NO,      16'h0000, 16'h00F8, 4'b0100));
    vb.push_back(mk(NO,      16'h0000, 16'h00FC, 4'b0100));
    vb.push_back(mk(NO,      16'h0000, 16'h0000, 4'b0100));
    vb.push_back(mk(CA,      16'h0010, 16'h0010, 4'b0000));
    vb.push_back(mk(CA,      16'h0020, 16'h0020, 4'b0000));
    vb.push_back(mk(CA,      16'h0030, 16'h0030, 4'b0010));
    vb.push_back(mk(CA,      16'h0040, 16'h0040, 4'b0011));
    vb.push_back(mk(RT,      16'h0000, 16'h0034, 4'b0000));
    vb.push_back(mk(RT,      16'h0000, 16'h0024, 4'b0000));
    vb.push_back(mk(RT,      16'h0000, 16'h0014, 4'b0100));
    vb.push_back(mk(RT,      16'h0055, 16'h0055, 4'b0101));
    vb.push_back(mk(RD,      16'h00FC, 16'h00FC, 4'b0100));
    vb.push_back(mk(CA,      16'h0080, 16'h0080, 4'b0000));
    vb.push_back(mk(RT,      16'h0000, 16'h0000, 4'b0100));
    vb.push_back(mk(CA,      16'h0010, 16'h0010, 4'b0000));
    vb.push_back(mk(CA,      16'h0020, 16'h0020, 4'b0000));
    vb.push_back(mk(CA,      16'h0030, 16'h0030, 4'b0010));
    vb.push_back(mk(HA,      16'h0000, 16'h0030, 4'b1010));
    vb.push_back(mk(R|RS|CA, 16'h0000, 16'h00F0, 4'b0100));
    vb.push_back(mk(NO,      16'h0000, 16'h00F4, 4'b0100));

    foreach (va[i]) apply(va[i], 1'b0, "vec_a", i);

    // Back-to-back call/ret at full rate on the default instance.
    apply(mk(R,  16'h0000, 16'h0000, 4'b0100), 1'b0, "b2b_rst", 0);
    apply(mk(CA, 16'h0040, 16'h0040, 4'b0000), 1'b0, "b2b_call", 1);
    apply(mk(RT, 16'h0000, 16'h0002, 4'b0100), 1'b0, "b2b_ret", 2);
    apply(mk(CA, 16'h0060, 16'h0060, 4'b0000), 1'b0, "b2b_call", 3);
    apply(mk(CA, 16'h0070, 16'h0070, 4'b0000), 1'b0, "b2b_call", 4);
    apply(mk(RT, 16'h0000, 16'h0062, 4'b0000), 1'b0, "b2b_ret", 5);
    apply(mk(RT, 16'h0000, 16'h0004, 4'b0100), 1'b0, "b2b_ret", 6);

    foreach (vb[i]) apply(vb[i], 1'b1, "vec_b", i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter stage for the pipelined datapath. It holds the fetch address and advances it by a fixed instruction step. It accepts stall, halt/resume and redirect requests from later stages, and keeps a small return-address stack (RAS) so call/return redirects resolve without an external target. It replaces the fixed 16-bit PC register, which had only halt and stall.

## Interface
Parameters:
- WIDTH, 16, PC and target width in bits
- STEP, 2, sequential increment in bytes
- RESET_VECTOR, 0, PC value after reset
- RAS_DEPTH, 4, return-address stack entries (>= 2)

Ports:
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  reset, synchronous, active-high
- stall  in  1  hold PC this cycle (hazard)
- halt  in  1  enter HALTED
- resume  in  1  leave HALTED
- redirect  in  1  jump to redirect_pc
- call  in  1  push return address pc+STEP, jump to redirect_pc
- ret  in  1  pop RAS, jump to popped address
- redirect_pc  in  WIDTH  target for redirect/call; fallback for ret on empty RAS
- pc  out  WIDTH  current fetch address (registered)
- halted  out  1  1 while in HALTED (registered)
- ras_empty  out  1  RAS holds 0 entries
- ras_full  out  1  RAS holds RAS_DEPTH entries
- ras_err  out  1  one-cycle pulse on RAS overflow or underflow

## Operation
- States: RUN, HALTED. Reset enters RUN.
- Reset (rst=1 at edge) overrides everything:
  - pc=RESET_VECTOR, halted=0
  - RAS count=0, ras_empty=1, ras_full=0, ras_err=0
- RUN, per-edge priority (first match wins):
  1. halt: state→HALTED, pc unchanged, RAS unchanged.
  2. ret: pc←top of RAS, count−1.
     - If the RAS is empty: pc←redirect_pc, count stays 0, ras_err pulses.
  3. call: push pc+STEP, pc←redirect_pc.
     - If the RAS is full: the oldest entry is discarded (circular overwrite), count stays RAS_DEPTH, ras_err pulses.
  4. redirect: pc←redirect_pc.
  5. stall: pc unchanged.
  6. Otherwise: pc←pc+STEP.
- Redirect-class inputs (ret/call/redirect) beat stall; a flush always wins over a hazard hold.
- Lower-priority inputs asserted in the same cycle are ignored entirely, with no RAS side effects.
- HALTED:
  - pc and RAS frozen.
  - stall, redirect, call and ret are ignored.
  - resume alone: state→RUN, pc unchanged. Sequential increment resumes on the following cycle.
  - halt and resume together: stays HALTED.
- Arithmetic: pc+STEP is computed modulo 2^WIDTH, so an all-ones region wraps to low addresses without error. redirect_pc is used unaligned, as given.
- The RAS is LIFO, with a write pointer of clog2(RAS_DEPTH) bits plus a count.
- Flags are registered and derived from the count: ras_empty = (count==0), ras_full = (count==RAS_DEPTH).

## Timing
- All outputs change only on rising clk; there are no combinational input→output paths.
- Every request has one-cycle latency: an input sampled at edge t is reflected in pc/halted after edge t.
- halted rises the edge after halt is sampled, and falls the edge after resume is sampled.
- ras_err is high for exactly the one cycle following the offending edge.
- Back-to-back call/ret on consecutive cycles is supported at full rate.
- Reset mid-operation (e.g. in HALTED, or with a full RAS) clears the state in one edge; no other input is honoured that cycle.

## Test plan
- Reset, then 4 free-run cycles → pc = 0x0000, 0x0002, 0x0004, 0x0006, 0x0008; halted=0, ras_empty=1.
- stall with redirect=1, redirect_pc=0x0100 in the same cycle → pc=0x0100 (redirect wins). Then stall alone for 2 cycles → pc held at 0x0100.
- Call sequence:
  - At pc=0x0010, call with redirect_pc=0x0200 → pc=0x0200, ras_empty=0.
  - Two sequential cycles → pc=0x0204.
  - ret → pc=0x0012, ras_empty=1.
- Five calls at pc=0x10, 0x20, 0x30, 0x40, 0x50, each jumping to the next address:
  - The fifth call → ras_err pulses once, ras_full=1.
  - Four rets → pops 0x52, 0x42, 0x32, 0x22.
  - A fifth ret with redirect_pc=0x0900 → pc=0x0900, ras_err pulse.
- halt at pc=0x0030 with ret same cycle → halted=1, pc=0x0030, RAS unchanged.
  - redirect/stall/call in HALTED → no change.
  - halt+resume together → still halted.
  - resume alone → halted=0; the next edge gives pc=0x0032.
- WIDTH=8, STEP=4, pc=0xFC → pc=0x00. rst asserted while HALTED with a full RAS → pc=RESET_VECTOR, halted=0, ras_empty=1 after one edge.
